// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types and constants for the 5-stage CPU sequencer.
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RUN     = 2'd1,
    MD_BUSY = 2'd2
  } state_t;

  localparam int REG_W = 5;
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Bit positions of each pipeline register in the enable/clear vectors
  localparam int STG_PC    = 0;
  localparam int STG_IFID  = 1;
  localparam int STG_IDEX  = 2;
  localparam int STG_EXMEM = 3;
  localparam int STG_MEMWB = 4;
  localparam int NUM_STG   = 5;

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_tracker.sv
// Sequencer FSM plus mult/div occupancy counter; counts even while the pipeline is frozen.
module md_busy_tracker
  import cpu_pipe_pkg::*;
#(
  parameter int MD_LAT = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       md_start,
  input  logic       ext_stall,
  output logic [1:0] state_dbg,
  output logic       md_busy,
  output logic       md_done
);

  localparam logic [7:0] MD_CNT_LOAD = 8'(MD_LAT - 1);

  state_t     state;
  logic [7:0] md_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= INIT;
      md_cnt <= 8'd0;
    end else begin
      case (state)
        INIT: state <= RUN;
        RUN: begin
          if (md_start && !ext_stall) begin
            state  <= MD_BUSY;
            md_cnt <= MD_CNT_LOAD;
          end
        end
        MD_BUSY: begin
          // A start seen here is an illegal overlap and is dropped
          if (md_cnt == 8'd0) state <= RUN;
          else                md_cnt <= md_cnt - 8'd1;
        end
        default: state <= INIT;
      endcase
    end
  end

  assign state_dbg = state;
  assign md_busy   = (state == MD_BUSY);
  assign md_done   = (state == MD_BUSY) && (md_cnt == 8'd0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush sequencer. Optional perf counters enabled by HAZ_PERF_CNT_EN.
// Handshake: no valid/ready; all controls are level signals evaluated each cycle.
module hazard_stall_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int MD_LAT = 32,
  parameter int REG_W  = cpu_pipe_pkg::REG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_hilo_dep,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic [REG_W-1:0] ex_wbreg,
  input  logic             ex_md_start,
  input  logic             ex_branch_taken,
  input  logic             ext_stall,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_clr,
  output logic             idex_clr,
  output logic             exmem_clr,
  output logic             memwb_clr,
  output logic             idex_bb,
  output logic             md_busy,
  output logic             md_done,
`ifdef HAZ_PERF_CNT_EN
  output logic [31:0]      perf_stall_cyc,
  output logic [31:0]      perf_flush_cnt,
  output logic [31:0]      perf_md_cyc,
`endif
  output logic [1:0]       state_dbg
);

  logic [NUM_STG-1:0] en_v;
  logic [NUM_STG-1:0] clr_v;
  logic               bb;
  logic               lu_haz;
  logic               md_haz;
  logic               br_flush;
  logic               in_init;

  md_busy_tracker #(.MD_LAT(MD_LAT)) u_md (
    .clk       (clk),
    .rst_n     (rst_n),
    .md_start  (ex_md_start),
    .ext_stall (ext_stall),
    .state_dbg (state_dbg),
    .md_busy   (md_busy),
    .md_done   (md_done)
  );

  assign in_init = (state_dbg == INIT);
  assign md_haz  = (state_dbg == MD_BUSY) && id_hilo_dep;
  assign lu_haz  = ex_memread && ex_regwrite && (ex_wbreg != REG_W'(REG_ZERO)) &&
                   ((id_uses_rs && (id_rs == ex_wbreg)) ||
                    (id_uses_rt && (id_rt == ex_wbreg)));

  // ext_stall beats branch flush, which beats both front-end hazards
  always_comb begin
    en_v     = '1;
    clr_v    = '0;
    bb       = 1'b0;
    br_flush = 1'b0;
    if (in_init) begin
      en_v  = '0;
      clr_v = '1;
    end else if (ext_stall) begin
      en_v = '0;
    end else if (ex_branch_taken) begin
      br_flush         = 1'b1;
      clr_v[STG_IFID]  = 1'b1;
      clr_v[STG_IDEX]  = 1'b1;
    end else if (md_haz || lu_haz) begin
      en_v[STG_PC]   = 1'b0;
      en_v[STG_IFID] = 1'b0;
      en_v[STG_IDEX] = 1'b0;
      bb             = 1'b1;
    end
  end

  assign pc_en     = en_v[STG_PC];
  assign ifid_en   = en_v[STG_IFID];
  assign idex_en   = en_v[STG_IDEX];
  assign exmem_en  = en_v[STG_EXMEM];
  assign memwb_en  = en_v[STG_MEMWB];
  assign ifid_clr  = clr_v[STG_IFID];
  assign idex_clr  = clr_v[STG_IDEX];
  assign exmem_clr = clr_v[STG_EXMEM];
  assign memwb_clr = clr_v[STG_MEMWB];
  assign idex_bb   = bb;

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cyc <= 32'd0;
      perf_flush_cnt <= 32'd0;
      perf_md_cyc    <= 32'd0;
    end else begin
      if (!pc_en && !ext_stall && (perf_stall_cyc != 32'hFFFF_FFFF))
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (br_flush && (perf_flush_cnt != 32'hFFFF_FFFF))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (md_busy && (perf_md_cyc != 32'hFFFF_FFFF))
        perf_md_cyc <= perf_md_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with MD_LAT=4; expectations are hand-computed.
module tb_hazard_stall_ctrl;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_MD   = 2'd2;

  // enables ordered {pc, ifid, idex, exmem, memwb}; clears ordered {ifid, idex, exmem, memwb}
  localparam logic [4:0] EN_ALL   = 5'b11111;
  localparam logic [4:0] EN_NONE  = 5'b00000;
  localparam logic [4:0] EN_STALL = 5'b00011;
  localparam logic [3:0] CLR_ALL  = 4'b1111;
  localparam logic [3:0] CLR_NONE = 4'b0000;
  localparam logic [3:0] CLR_BR   = 4'b1100;

  // clock/reset block
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] id_rs, id_rt, ex_wbreg;
  logic id_uses_rs, id_uses_rt, id_hilo_dep, ex_memread, ex_regwrite;
  logic ex_md_start, ex_branch_taken, ext_stall;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_clr, idex_clr, exmem_clr, memwb_clr;
  logic idex_bb, md_busy, md_done;
  logic [1:0] state_dbg;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_md_cyc;
`endif

  hazard_stall_ctrl #(.MD_LAT(4), .REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_hilo_dep(id_hilo_dep), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
    .ex_wbreg(ex_wbreg), .ex_md_start(ex_md_start), .ex_branch_taken(ex_branch_taken),
    .ext_stall(ext_stall),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_clr(ifid_clr), .idex_clr(idex_clr),
    .exmem_clr(exmem_clr), .memwb_clr(memwb_clr), .idex_bb(idex_bb),
    .md_busy(md_busy), .md_done(md_done),
`ifdef HAZ_PERF_CNT_EN
    .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt),
    .perf_md_cyc(perf_md_cyc),
`endif
    .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard: expected tokens pushed per step, popped and compared against observed
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ctrl(input string tag, input logic [4:0] en, input logic [3:0] clr,
                             input logic bb, input logic busy, input logic done);
    exp_q.push_back(32'(en));
    exp_q.push_back(32'(clr));
    exp_q.push_back(32'({bb, busy, done}));
    check({tag, ".en"},  32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), exp_q.pop_front());
    check({tag, ".clr"}, 32'({ifid_clr, idex_clr, exmem_clr, memwb_clr}), exp_q.pop_front());
    check({tag, ".bb_busy_done"}, 32'({idex_bb, md_busy, md_done}), exp_q.pop_front());
  endtask

  task automatic expect_state(input string tag, input logic [1:0] st);
    check({tag, ".state"}, 32'(state_dbg), 32'(st));
  endtask

  // driver tasks
  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_wbreg = '0;
    id_uses_rs = 0; id_uses_rt = 0; id_hilo_dep = 0;
    ex_memread = 0; ex_regwrite = 0; ex_md_start = 0;
    ex_branch_taken = 0; ext_stall = 0;
  endtask

  task automatic drive_load(input logic [4:0] wb, input logic [4:0] rs, input logic urs,
                            input logic [4:0] rt, input logic urt);
    ex_memread = 1; ex_regwrite = 1; ex_wbreg = wb;
    id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
  endtask

  // advance one clock and land 1 time unit after the edge, then let inputs settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    clear_inputs();
    #2;
    expect_ctrl("reset", EN_NONE, CLR_ALL, 0, 0, 0);
    expect_state("reset", ST_INIT);

    // release between edges; INIT holds until the next rising edge
    #20;
    rst_n = 1'b1;
    settle();
    expect_ctrl("init_after_release", EN_NONE, CLR_ALL, 0, 0, 0);
    tick();
    expect_ctrl("run_first", EN_ALL, CLR_NONE, 0, 0, 0);
    expect_state("run_first", ST_RUN);

    // load-use on rs
    drive_load(5'd8, 5'd8, 1, 5'd3, 0);
    settle();
    expect_ctrl("lu_rs", EN_STALL, CLR_NONE, 1, 0, 0);
    tick();
    clear_inputs();
    settle();
    expect_ctrl("lu_resolved", EN_ALL, CLR_NONE, 0, 0, 0);

    // load to $zero never stalls
    drive_load(5'd0, 5'd0, 1, 5'd0, 1);
    settle();
    expect_ctrl("lu_zero", EN_ALL, CLR_NONE, 0, 0, 0);
    tick();

    // load-use on rt, then rt matching but unused, then non-writing load
    drive_load(5'd9, 5'd1, 1, 5'd9, 1);
    settle();
    expect_ctrl("lu_rt", EN_STALL, CLR_NONE, 1, 0, 0);
    id_uses_rt = 0;
    settle();
    expect_ctrl("lu_rt_unused", EN_ALL, CLR_NONE, 0, 0, 0);
    id_uses_rt = 1; ex_regwrite = 0;
    settle();
    expect_ctrl("lu_no_regwrite", EN_ALL, CLR_NONE, 0, 0, 0);

    // branch beats load-use
    ex_regwrite = 1; ex_branch_taken = 1;
    settle();
    expect_ctrl("branch_over_lu", EN_ALL, CLR_BR, 0, 0, 0);
    tick();
    clear_inputs();

    // MD occupancy: 4 busy cycles, done on the 4th, illegal restart ignored
    ex_md_start = 1;
    settle();
    expect_ctrl("md_issue", EN_ALL, CLR_NONE, 0, 0, 0);
    tick();
    ex_md_start = 0; id_hilo_dep = 1;
    settle();
    expect_ctrl("md_c1", EN_STALL, CLR_NONE, 1, 1, 0);
    expect_state("md_c1", ST_MD);
    tick();
    ex_md_start = 1;
    settle();
    expect_ctrl("md_c2", EN_STALL, CLR_NONE, 1, 1, 0);
    tick();
    ex_md_start = 0;
    settle();
    expect_ctrl("md_c3", EN_STALL, CLR_NONE, 1, 1, 0);
    tick();
    expect_ctrl("md_c4_done", EN_STALL, CLR_NONE, 1, 1, 1);
    tick();
    expect_ctrl("md_released", EN_ALL, CLR_NONE, 0, 0, 0);
    expect_state("md_released", ST_RUN);
    clear_inputs();

    // start is not accepted while frozen
    ex_md_start = 1; ext_stall = 1;
    settle();
    expect_ctrl("start_frozen", EN_NONE, CLR_NONE, 0, 0, 0);
    tick();
    expect_ctrl("start_frozen_ignored", EN_NONE, CLR_NONE, 0, 0, 0);

    // start together with branch: flushed front end, issue accepted
    ext_stall = 0; ex_branch_taken = 1;
    settle();
    expect_ctrl("start_with_branch", EN_ALL, CLR_BR, 0, 0, 0);
    tick();
    ex_md_start = 0; ext_stall = 1;
    drive_load(5'd8, 5'd8, 1, 5'd0, 0);
    settle();
    expect_ctrl("xstall_1", EN_NONE, CLR_NONE, 0, 1, 0);
    tick();
    expect_ctrl("xstall_2", EN_NONE, CLR_NONE, 0, 1, 0);
    tick();
    expect_ctrl("xstall_3", EN_NONE, CLR_NONE, 0, 1, 0);
    tick();
    ext_stall = 0;
    settle();
    expect_ctrl("xstall_release_flush", EN_ALL, CLR_BR, 0, 1, 1);
    tick();
    clear_inputs();
    settle();
    expect_ctrl("after_md2", EN_ALL, CLR_NONE, 0, 0, 0);

    // asynchronous reset in the middle of a busy period
    ex_md_start = 1;
    tick();
    ex_md_start = 0;
    settle();
    expect_ctrl("md3_busy", EN_ALL, CLR_NONE, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_ctrl("mid_reset", EN_NONE, CLR_ALL, 0, 0, 0);
    expect_state("mid_reset", ST_INIT);
    tick();
    rst_n = 1'b1;
    settle();
    expect_ctrl("mid_reset_init", EN_NONE, CLR_ALL, 0, 0, 0);
    tick();
    expect_ctrl("mid_reset_run", EN_ALL, CLR_NONE, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Central pipeline sequencer for the 5-stage CPU.
- Drives enable, clear and bubble controls of the PC, IFtoID, IDtoEX, EXtoMEM and MEMtoWB registers.
- Resolves load-use hazards, taken-branch flushes, external memory waits and multi-cycle MULT/DIV occupancy of HI/LO.
- Holds the pipeline cleared for one cycle after reset.

Parameters:
MD_LAT, 32, busy cycles of the mult/div unit after issue (legal 2..255)
REG_W, 5, register-number width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs  in  REG_W  source register 1 of the ID-stage instruction
id_rt  in  REG_W  source register 2 of the ID-stage instruction
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_hilo_dep  in  1  ID instruction is MFHI/MFLO/MTHI/MTLO/MULT/DIV
ex_memread  in  1  EX-stage instruction is a load
ex_regwrite  in  1  EX-stage instruction writes a register
ex_wbreg  in  REG_W  EX-stage destination register
ex_md_start  in  1  EX-stage instruction issues MULT/DIV this cycle
ex_branch_taken  in  1  branch/jump resolved taken in EX
ext_stall  in  1  memory not ready; freeze entire pipeline
pc_en  out  1  PC update enable
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register enables
ifid_clr, idex_clr, exmem_clr, memwb_clr  out  1 each  synchronous clears
idex_bb  out  1  insert bubble into IDtoEX when its enable is low
md_busy  out  1  mult/div unit occupied
md_done  out  1  one-cycle pulse on the last busy cycle

Behaviour:
- States: INIT, RUN, MD_BUSY. Counter md_cnt is 8 bits.
- While rst_n=0:
  - State=INIT, md_cnt=0.
  - Outputs: all *_en=0, all *_clr=1, idex_bb=0, md_busy=0, md_done=0.
- INIT:
  - Outputs are the same as in reset.
  - Next cycle goes to RUN unconditionally.
- Default outputs in RUN/MD_BUSY: all en=1, all clr=0, idex_bb=0.
- Output priority, highest first:
  1. ext_stall=1:
     - All en=0, no clr, no bubble.
     - ex_branch_taken and hazards are ignored; they are re-presented after release.
  2. ex_branch_taken=1: ifid_clr=1, idex_clr=1. No stall even if a hazard is detected.
  3. MD hazard (state=MD_BUSY and id_hilo_dep=1):
     - pc_en=0, ifid_en=0, idex_en=0, idex_bb=1.
     - EXtoMEM and MEMtoWB keep running.
  4. Load-use hazard:
     - Condition: ex_memread & ex_regwrite & ex_wbreg!=0 & ((id_uses_rs & id_rs==ex_wbreg) | (id_uses_rt & id_rt==ex_wbreg)).
     - Outputs are the same as the MD hazard.
     - The stall resolves itself the next cycle.
- All stall/flush outputs are combinational from state and inputs; no added latency.
- RUN→MD_BUSY:
  - Trigger: ex_md_start=1 and ext_stall=0.
  - Action: md_cnt <= MD_LAT-1.
- MD_BUSY:
  - md_busy=1.
  - md_cnt decrements every cycle, including during ext_stall (the unit runs independently).
  - md_done=1 when md_cnt=0; the next state is RUN.
- ex_md_start while in MD_BUSY: cannot occur legally, because ID is stalled on id_hilo_dep. If asserted anyway, it is ignored and does not reload md_cnt.
- ex_md_start together with ex_branch_taken: the MD instruction is older than the branch, so issue is accepted.
- Reset asserted mid-operation: immediate return to INIT, md_cnt cleared.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined:
  - Adds outputs perf_stall_cyc[31:0], perf_flush_cnt[31:0] and perf_md_cyc[31:0].
  - They count, respectively, cycles with pc_en=0 and ext_stall=0; cycles with ifid_clr from a branch; and cycles in MD_BUSY.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_pipe_pkg:
  - state enum {INIT, RUN, MD_BUSY}
  - REG_W
  - REG_ZERO = 5'd0
  - stage index constants
- One natural sub-module, md_busy_tracker: md_cnt, md_busy and md_done, with ext_stall-independent counting.
- Hazard and priority logic stays in the top module.

Test Plan:
- Reset, then release: cycle after release has all clr=1 and en=0; the following cycle has all en=1, clr=0.
- Load-use stall: ex_memread=1, ex_regwrite=1, ex_wbreg=8, id_uses_rs=1, id_rs=8 → for exactly one cycle pc_en=ifid_en=idex_en=0, idex_bb=1, exmem_en=1. Repeated with ex_wbreg=0 → no stall.
- MD occupancy, MD_LAT=4:
  - ex_md_start pulse → md_busy high for 4 cycles; md_done on the 4th.
  - id_hilo_dep=1 during busy → front stalled each cycle; released on the cycle after md_done.
- Branch over hazard: ex_branch_taken=1 with load-use conditions true → ifid_clr=idex_clr=1, pc_en=1, idex_bb=0.
- ext_stall=1 for 3 cycles, during MD_BUSY and with branch_taken=1 → all en=0, no clr; md_cnt still decrements 3; flush occurs on the first cycle after release.
- rst_n pulsed low mid-MD_BUSY → md_busy=0 asynchronously, state INIT, all clr=1.
